multicycle_cu: RTL and testbench

- Next-generation MIPS control unit: a multi-cycle FSM replacing the single-cycle combinational decoder.
- Sequences FETCH/DECODE/EXECUTE/MEM/WRITEBACK per instruction and stalls on a memory ready handshake.
- Holds EXECUTE for a parametrised multiply/divide latency and detects memory timeouts.
- Sits between the instruction register/shared memory port and the datapath muxes, register file and ALU. ALUOp encodings come from the shared ALU option macros.

---
 rtl/multicycle_cu_if.sv | 10 +
 rtl/multicycle_cu.sv | 283 ++++++++++++++++++++++++++++
 tb/tb_multicycle_cu.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_cu_if.sv
// rtl/multicycle_cu_if.sv - shared memory port handshake between the control unit and memory
interface multicycle_cu_if;
  logic mem_ready;
  logic MemRead;
  logic MemWrite;
  logic IorD;

  modport master (input mem_ready, output MemRead, output MemWrite, output IorD);
  modport slave  (output mem_ready, input MemRead, input MemWrite, input IorD);
endinterface

// File: rtl/multicycle_cu.sv
// rtl/multicycle_cu.sv - multi-cycle MIPS control unit FSM; MULTICYCLE_CU_ILLEGAL_TRAP_EN traps unknown instructions
module multicycle_cu #(
  parameter int ALUOP_W       = 5,
  parameter int MULDIV_CYCLES = 4,
  parameter int MEM_TIMEOUT   = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         opcode,
  input  logic [5:0]         func,
  input  logic               alu_zero,
  multicycle_cu_if.master    mem,
  output logic               PCWrite,
  output logic               IRWrite,
  output logic               MemToReg,
  output logic               RegDest,
  output logic               RegWrite,
  output logic               Link,
  output logic               ALUsrc,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic               Jump,
  output logic               JumpReg,
  output logic               Branch,
  output logic               SignExtend,
  output logic               Halted,
  output logic               busy
`ifdef MULTICYCLE_CU_ILLEGAL_TRAP_EN
  ,
  output logic               exc_pulse
`endif
);

  // ALU operation codes shared with the ALU
  localparam logic [ALUOP_W-1:0] ALU_ADD   = ALUOP_W'(0);
  localparam logic [ALUOP_W-1:0] ALU_ADDU  = ALUOP_W'(1);
  localparam logic [ALUOP_W-1:0] ALU_SUB   = ALUOP_W'(2);
  localparam logic [ALUOP_W-1:0] ALU_SUBU  = ALUOP_W'(3);
  localparam logic [ALUOP_W-1:0] ALU_AND   = ALUOP_W'(4);
  localparam logic [ALUOP_W-1:0] ALU_OR    = ALUOP_W'(5);
  localparam logic [ALUOP_W-1:0] ALU_XOR   = ALUOP_W'(6);
  localparam logic [ALUOP_W-1:0] ALU_NOR   = ALUOP_W'(7);
  localparam logic [ALUOP_W-1:0] ALU_SLT   = ALUOP_W'(8);
  localparam logic [ALUOP_W-1:0] ALU_SLTU  = ALUOP_W'(9);
  localparam logic [ALUOP_W-1:0] ALU_SLL   = ALUOP_W'(10);
  localparam logic [ALUOP_W-1:0] ALU_SRL   = ALUOP_W'(11);
  localparam logic [ALUOP_W-1:0] ALU_SRA   = ALUOP_W'(12);
  localparam logic [ALUOP_W-1:0] ALU_LUI   = ALUOP_W'(13);
  localparam logic [ALUOP_W-1:0] ALU_MULT  = ALUOP_W'(14);
  localparam logic [ALUOP_W-1:0] ALU_MULTU = ALUOP_W'(15);
  localparam logic [ALUOP_W-1:0] ALU_DIV   = ALUOP_W'(16);
  localparam logic [ALUOP_W-1:0] ALU_DIVU  = ALUOP_W'(17);
  // Branch compares: the ALU result is zero exactly when the branch is taken
  localparam logic [ALUOP_W-1:0] ALU_SEQ   = ALUOP_W'(18);
  localparam logic [ALUOP_W-1:0] ALU_SGTZ  = ALUOP_W'(19);
  localparam logic [ALUOP_W-1:0] ALU_SLEZ  = ALUOP_W'(20);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_BLEZ  = 6'b000110;
  localparam logic [5:0] OP_BGTZ  = 6'b000111;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam int WAIT_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam int CNT_W  = (MULDIV_CYCLES < 2) ? 1 : $clog2(MULDIV_CYCLES);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT, S_TRAP
  } state_t;

  typedef enum logic [3:0] {
    C_RALU, C_MULDIV, C_IALU, C_LW, C_SW, C_BR, C_J, C_JR, C_JAL, C_BAD
  } cls_t;

  state_t             state_q, state_d;
  logic [WAIT_W-1:0]  wait_q, wait_d, wait_inc;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [5:0]         op_q, op_d, fn_q, fn_d;
  logic               wait_hit;

  cls_t               cls;
  logic [ALUOP_W-1:0] dec_aop;
  logic               dec_sx;

  logic o_pcw, o_irw, o_iord, o_mr, o_mw, o_m2r, o_rd, o_rw, o_link;
  logic o_src, o_j, o_jr, o_br, o_sx, o_halt;
  logic [ALUOP_W-1:0] o_aop;
`ifdef MULTICYCLE_CU_ILLEGAL_TRAP_EN
  logic o_exc;
`endif

  assign wait_inc = wait_q + WAIT_W'(1);
  assign wait_hit = (MEM_TIMEOUT != 0) && (wait_inc == WAIT_W'(MEM_TIMEOUT));

  // Classify the latched instruction and pick its ALU operation
  always_comb begin
    cls     = C_BAD;
    dec_aop = ALU_ADD;
    dec_sx  = 1'b0;
    case (op_q)
      OP_RTYPE: begin
        cls = C_RALU;
        case (fn_q)
          6'b100000: dec_aop = ALU_ADD;
          6'b100001: dec_aop = ALU_ADDU;
          6'b100010: dec_aop = ALU_SUB;
          6'b100011: dec_aop = ALU_SUBU;
          6'b100100: dec_aop = ALU_AND;
          6'b100101: dec_aop = ALU_OR;
          6'b100110: dec_aop = ALU_XOR;
          6'b100111: dec_aop = ALU_NOR;
          6'b101010: dec_aop = ALU_SLT;
          6'b101011: dec_aop = ALU_SLTU;
          6'b000000: dec_aop = ALU_SLL;
          6'b000010: dec_aop = ALU_SRL;
          6'b000011: dec_aop = ALU_SRA;
          6'b011000: begin cls = C_MULDIV; dec_aop = ALU_MULT;  end
          6'b011001: begin cls = C_MULDIV; dec_aop = ALU_MULTU; end
          6'b011010: begin cls = C_MULDIV; dec_aop = ALU_DIV;   end
          6'b011011: begin cls = C_MULDIV; dec_aop = ALU_DIVU;  end
          6'b001000: cls = C_JR;
          default:   cls = C_BAD;
        endcase
      end
      OP_ADDI:  begin cls = C_IALU; dec_aop = ALU_ADD;  dec_sx = 1'b1; end
      OP_ADDIU: begin cls = C_IALU; dec_aop = ALU_ADDU; end
      OP_SLTI:  begin cls = C_IALU; dec_aop = ALU_SLT;  dec_sx = 1'b1; end
      OP_ANDI:  begin cls = C_IALU; dec_aop = ALU_AND;  end
      OP_ORI:   begin cls = C_IALU; dec_aop = ALU_OR;   end
      OP_XORI:  begin cls = C_IALU; dec_aop = ALU_XOR;  end
      OP_LUI:   begin cls = C_IALU; dec_aop = ALU_LUI;  dec_sx = 1'b1; end
      OP_LW:    begin cls = C_LW;   dec_aop = ALU_ADD;  dec_sx = 1'b1; end
      OP_SW:    begin cls = C_SW;   dec_aop = ALU_ADD;  dec_sx = 1'b1; end
      OP_BEQ:   begin cls = C_BR;   dec_aop = ALU_SUB;  dec_sx = 1'b1; end
      OP_BNE:   begin cls = C_BR;   dec_aop = ALU_SEQ;  dec_sx = 1'b1; end
      OP_BLEZ:  begin cls = C_BR;   dec_aop = ALU_SGTZ; dec_sx = 1'b1; end
      OP_BGTZ:  begin cls = C_BR;   dec_aop = ALU_SLEZ; dec_sx = 1'b1; end
      OP_J:     cls = C_J;
      OP_JAL:   cls = C_JAL;
      default:  cls = C_BAD;
    endcase
  end

  // Next state, counters and raw control outputs from state plus latched instruction
  always_comb begin
    state_d = state_q;
    wait_d  = '0;
    cnt_d   = cnt_q;
    op_d    = op_q;
    fn_d    = fn_q;
    o_pcw = 1'b0; o_irw = 1'b0; o_iord = 1'b0; o_mr  = 1'b0; o_mw   = 1'b0;
    o_m2r = 1'b0; o_rd  = 1'b0; o_rw   = 1'b0; o_link = 1'b0; o_src = 1'b0;
    o_j   = 1'b0; o_jr  = 1'b0; o_br   = 1'b0; o_sx  = 1'b0; o_halt = 1'b0;
    o_aop = '0;
`ifdef MULTICYCLE_CU_ILLEGAL_TRAP_EN
    o_exc = 1'b0;
`endif
    case (state_q)
      S_FETCH: begin
        o_mr = 1'b1;
        if (mem.mem_ready) begin
          o_irw   = 1'b1;
          o_pcw   = 1'b1;
          op_d    = opcode;
          fn_d    = func;
          state_d = S_DECODE;
        end else if (wait_hit) begin
          state_d = S_HALT;
        end else begin
          wait_d = wait_inc;
        end
      end
      S_DECODE: begin
        cnt_d = CNT_W'(MULDIV_CYCLES - 1);
`ifdef MULTICYCLE_CU_ILLEGAL_TRAP_EN
        state_d = (cls == C_BAD) ? S_TRAP : S_EXEC;
`else
        state_d = (cls == C_BAD) ? S_HALT : S_EXEC;
`endif
      end
      S_EXEC: begin
        case (cls)
          C_RALU:       begin o_rd = 1'b1; o_aop = dec_aop; state_d = S_WB; end
          C_MULDIV: begin
            o_rd  = 1'b1;
            o_aop = dec_aop;
            if (cnt_q == '0) state_d = S_WB;
            else             cnt_d = cnt_q - CNT_W'(1);
          end
          C_IALU:       begin o_src = 1'b1; o_sx = dec_sx; o_aop = dec_aop; state_d = S_WB; end
          C_LW, C_SW:   begin o_src = 1'b1; o_sx = 1'b1; o_aop = ALU_ADD; state_d = S_MEM; end
          C_BR: begin
            o_br    = 1'b1;
            o_sx    = 1'b1;
            o_aop   = dec_aop;
            o_pcw   = alu_zero;
            state_d = S_FETCH;
          end
          C_J:          begin o_j = 1'b1; o_pcw = 1'b1; state_d = S_FETCH; end
          C_JR:         begin o_j = 1'b1; o_jr = 1'b1; o_pcw = 1'b1; state_d = S_FETCH; end
          C_JAL:        begin o_j = 1'b1; o_pcw = 1'b1; o_rw = 1'b1; state_d = S_FETCH; end
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEM: begin
        o_iord = 1'b1;
        o_mr   = (cls == C_LW);
        o_mw   = (cls != C_LW);
        if (mem.mem_ready)  state_d = (cls == C_LW) ? S_WB : S_FETCH;
        else if (wait_hit) state_d = S_HALT;
        else               wait_d = wait_inc;
      end
      S_WB: begin
        // Link marks an ALU-sourced writeback; loads take the memory path instead
        o_rw    = 1'b1;
        o_m2r   = (cls == C_LW);
        o_link  = (cls != C_LW);
        o_rd    = (cls == C_RALU) || (cls == C_MULDIV);
        state_d = S_FETCH;
      end
      S_HALT: o_halt = 1'b1;
`ifdef MULTICYCLE_CU_ILLEGAL_TRAP_EN
      S_TRAP: begin
        o_pcw   = 1'b1;
        o_j     = 1'b1;
        o_exc   = 1'b1;
        state_d = S_FETCH;
      end
`endif
      default: state_d = S_FETCH;
    endcase
  end

  // State, wait/muldiv counters and latched instruction fields
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      wait_q  <= '0;
      cnt_q   <= '0;
      op_q    <= '0;
      fn_q    <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      fn_q    <= fn_d;
    end
  end

  // Every output is forced low while reset is held so an abandoned access never strobes
  assign PCWrite      = o_pcw  & ~rst;
  assign IRWrite      = o_irw  & ~rst;
  assign mem.IorD     = o_iord & ~rst;
  assign mem.MemRead  = o_mr   & ~rst;
  assign mem.MemWrite = o_mw   & ~rst;
  assign MemToReg     = o_m2r  & ~rst;
  assign RegDest      = o_rd   & ~rst;
  assign RegWrite     = o_rw   & ~rst;
  assign Link         = o_link & ~rst;
  assign ALUsrc       = o_src  & ~rst;
  assign ALUOp        = rst ? '0 : o_aop;
  assign Jump         = o_j    & ~rst;
  assign JumpReg      = o_jr   & ~rst;
  assign Branch       = o_br   & ~rst;
  assign SignExtend   = o_sx   & ~rst;
  assign Halted       = o_halt & ~rst;
  assign busy         = (state_q != S_FETCH) & ~rst;
`ifdef MULTICYCLE_CU_ILLEGAL_TRAP_EN
  assign exc_pulse    = o_exc  & ~rst;
`endif

endmodule

// File: tb/tb_multicycle_cu.sv
// tb/tb_multicycle_cu.sv - directed bench for multicycle_cu with a per-instruction cycle model
module tb_multicycle_cu;
  localparam int MULDIV_CYCLES = 4;
  localparam int MEM_TIMEOUT   = 15;

  // Output vector bit positions
  localparam int B_EXC = 21, B_PCW = 15, B_IRW = 14, B_IORD = 13, B_MR = 12, B_MW = 11;
  localparam int B_M2R = 10, B_RD = 9, B_RW = 8, B_LINK = 7, B_SRC = 6, B_J = 5;
  localparam int B_JR = 4, B_BR = 3, B_SX = 2, B_HALT = 1, B_BUSY = 0;

  localparam int K_R = 0, K_MD = 1, K_I = 2, K_LW = 3, K_SW = 4, K_BR = 5;
  localparam int K_J = 6, K_JR = 7, K_JAL = 8, K_BAD = 9;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [5:0] opcode = '0;
  logic [5:0] func = '0;
  logic alu_zero = 1'b0;
  logic PCWrite, IRWrite, MemToReg, RegDest, RegWrite, Link, ALUsrc;
  logic Jump, JumpReg, Branch, SignExtend, Halted, busy;
  logic [4:0] ALUOp;
  logic dut_exc;
  logic [21:0] dut_vec;

  multicycle_cu_if bus();

  multicycle_cu #(.ALUOP_W(5), .MULDIV_CYCLES(MULDIV_CYCLES), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .func(func), .alu_zero(alu_zero), .mem(bus.master),
    .PCWrite(PCWrite), .IRWrite(IRWrite), .MemToReg(MemToReg), .RegDest(RegDest),
    .RegWrite(RegWrite), .Link(Link), .ALUsrc(ALUsrc), .ALUOp(ALUOp), .Jump(Jump),
    .JumpReg(JumpReg), .Branch(Branch), .SignExtend(SignExtend), .Halted(Halted), .busy(busy)
`ifdef MULTICYCLE_CU_ILLEGAL_TRAP_EN
    , .exc_pulse(dut_exc)
`endif
  );

`ifndef MULTICYCLE_CU_ILLEGAL_TRAP_EN
  assign dut_exc = 1'b0;
`endif

  assign dut_vec = {dut_exc, ALUOp, PCWrite, IRWrite, bus.IorD, bus.MemRead, bus.MemWrite,
                    MemToReg, RegDest, RegWrite, Link, ALUsrc, Jump, JumpReg, Branch,
                    SignExtend, Halted, busy};

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        rdy;
    logic        zero;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [21:0] exp;
    logic [63:0] nm;
  } step_t;

  step_t q[$];
  int total = 0;
  int bad = 0;

  function automatic void push(input logic r, input logic rdy, input logic z, input logic [5:0] o,
                               input logic [5:0] f, input logic [21:0] e, input logic [63:0] nm);
    step_t s;
    s.rst = r; s.rdy = rdy; s.zero = z; s.op = o; s.fn = f; s.exp = e; s.nm = nm;
    q.push_back(s);
  endfunction

  // Instruction table: class, ALU code and immediate extension
  function automatic void classify(input logic [5:0] op, input logic [5:0] fn,
                                   output int cls, output logic [4:0] aop, output logic sx);
    cls = K_BAD; aop = 5'd0; sx = 1'b0;
    case (op)
      6'b000000: case (fn)
        6'b100000: begin cls = K_R;  aop = 5'd0;  end
        6'b100010: begin cls = K_R;  aop = 5'd2;  end
        6'b100101: begin cls = K_R;  aop = 5'd5;  end
        6'b011000: begin cls = K_MD; aop = 5'd14; end
        6'b011010: begin cls = K_MD; aop = 5'd16; end
        6'b001000: cls = K_JR;
        default:   cls = K_BAD;
      endcase
      6'b001000: begin cls = K_I;  aop = 5'd0;  sx = 1'b1; end
      6'b001101: begin cls = K_I;  aop = 5'd5;  end
      6'b001111: begin cls = K_I;  aop = 5'd13; sx = 1'b1; end
      6'b100011: cls = K_LW;
      6'b101011: cls = K_SW;
      6'b000100: begin cls = K_BR; aop = 5'd2;  end
      6'b000101: begin cls = K_BR; aop = 5'd18; end
      6'b000010: cls = K_J;
      6'b000011: cls = K_JAL;
      default:   cls = K_BAD;
    endcase
  endfunction

  // Expected cycle sequence of one instruction; keep>=0 truncates it and appends a reset cycle
  function automatic int add_instr(input logic [63:0] nm, input logic [5:0] op, input logic [5:0] fn,
                                   input int fw, input int mw, input logic zero, input int keep);
    int start, cls, reps;
    logic [4:0] aop;
    logic sx;
    logic [21:0] e;
    start = q.size();
    classify(op, fn, cls, aop, sx);
    for (int i = 0; i < fw; i++) begin
      e = '0; e[B_MR] = 1'b1; push(1'b0, 1'b0, zero, op, fn, e, nm);
    end
    e = '0; e[B_MR] = 1'b1; e[B_IRW] = 1'b1; e[B_PCW] = 1'b1;
    push(1'b0, 1'b1, zero, op, fn, e, nm);
    e = '0; e[B_BUSY] = 1'b1;
    push(1'b0, 1'b1, zero, ~op, ~fn, e, nm);
    if (cls == K_BAD) begin
`ifdef MULTICYCLE_CU_ILLEGAL_TRAP_EN
      e = '0; e[B_BUSY] = 1'b1; e[B_PCW] = 1'b1; e[B_J] = 1'b1; e[B_EXC] = 1'b1;
      push(1'b0, 1'b1, zero, ~op, ~fn, e, nm);
`else
      for (int i = 0; i < 3; i++) begin
        e = '0; e[B_BUSY] = 1'b1; e[B_HALT] = 1'b1; push(1'b0, 1'b1, zero, ~op, ~fn, e, nm);
      end
      push(1'b1, 1'b1, zero, ~op, ~fn, '0, nm);
`endif
    end else begin
      reps = (cls == K_MD) ? MULDIV_CYCLES : 1;
      for (int i = 0; i < reps; i++) begin
        e = '0; e[B_BUSY] = 1'b1;
        case (cls)
          K_R, K_MD:  begin e[B_RD] = 1'b1; e[20:16] = aop; end
          K_I:        begin e[B_SRC] = 1'b1; e[B_SX] = sx; e[20:16] = aop; end
          K_LW, K_SW: begin e[B_SRC] = 1'b1; e[B_SX] = 1'b1; end
          K_BR:       begin e[B_BR] = 1'b1; e[B_SX] = 1'b1; e[20:16] = aop; e[B_PCW] = zero; end
          K_J:        begin e[B_PCW] = 1'b1; e[B_J] = 1'b1; end
          K_JR:       begin e[B_PCW] = 1'b1; e[B_J] = 1'b1; e[B_JR] = 1'b1; end
          K_JAL:      begin e[B_PCW] = 1'b1; e[B_J] = 1'b1; e[B_RW] = 1'b1; end
          default:    ;
        endcase
        push(1'b0, 1'b1, zero, ~op, ~fn, e, nm);
      end
      if (cls == K_LW || cls == K_SW) begin
        e = '0; e[B_BUSY] = 1'b1; e[B_IORD] = 1'b1;
        if (cls == K_LW) e[B_MR] = 1'b1; else e[B_MW] = 1'b1;
        for (int i = 0; i < mw; i++) push(1'b0, 1'b0, zero, ~op, ~fn, e, nm);
        push(1'b0, 1'b1, zero, ~op, ~fn, e, nm);
      end
      if (cls == K_R || cls == K_MD || cls == K_I || cls == K_LW) begin
        e = '0; e[B_BUSY] = 1'b1; e[B_RW] = 1'b1;
        e[B_M2R] = (cls == K_LW);
        e[B_LINK] = (cls != K_LW);
        e[B_RD] = (cls == K_R || cls == K_MD);
        push(1'b0, 1'b1, zero, ~op, ~fn, e, nm);
      end
    end
    if (keep >= 0) begin
      while (q.size() > start + keep) void'(q.pop_back());
      push(1'b1, 1'b1, zero, ~op, ~fn, '0, nm);
    end
    return q.size() - start;
  endfunction

  // FETCH starved of mem_ready until the timeout halts, then a reset pulse
  function automatic void add_timeout();
    logic [21:0] e;
    for (int i = 0; i < MEM_TIMEOUT; i++) begin
      e = '0; e[B_MR] = 1'b1; push(1'b0, 1'b0, 1'b0, 6'h00, 6'h20, e, "TIMEOUT");
    end
    for (int i = 0; i < 3; i++) begin
      e = '0; e[B_BUSY] = 1'b1; e[B_HALT] = 1'b1; push(1'b0, 1'b1, 1'b0, 6'h00, 6'h20, e, "HALTED");
    end
    push(1'b1, 1'b1, 1'b0, 6'h00, 6'h20, '0, "RSTHALT");
  endfunction

  task automatic chk_int(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d expected=%0d", name, act, exp);
    end
  endtask

  initial begin
    int n, mstart, rw_idx;
    bus.mem_ready = 1'b0;
    push(1'b1, 1'b1, 1'b0, 6'h00, 6'h20, '0, "RESET");
    push(1'b1, 1'b1, 1'b0, 6'h00, 6'h20, '0, "RESET");
    n = add_instr("ADD", 6'b000000, 6'b100000, 0, 0, 1'b0, -1);  chk_int("len_add", n, 4);
    n = add_instr("LW", 6'b100011, 6'h00, 0, 3, 1'b0, -1);        chk_int("len_lw_wait3", n, 8);
    n = add_instr("BEQ_T", 6'b000100, 6'h00, 0, 0, 1'b1, -1);     chk_int("len_beq", n, 3);
    n = add_instr("BEQ_N", 6'b000100, 6'h00, 0, 0, 1'b0, -1);
    mstart = q.size();
    n = add_instr("MULT", 6'b000000, 6'b011000, 0, 0, 1'b0, -1);  chk_int("len_mult", n, 7);
    rw_idx = -1;
    for (int i = n - 1; i >= 0; i--) if (q[mstart + i].exp[B_RW]) rw_idx = i;
    chk_int("mult_regwrite_cycle", rw_idx, 6);
    n = add_instr("SW", 6'b101011, 6'h00, 0, 0, 1'b0, -1);        chk_int("len_sw", n, 4);
    n = add_instr("ADDI", 6'b001000, 6'h00, 0, 0, 1'b0, -1);
    n = add_instr("LUI", 6'b001111, 6'h00, 0, 0, 1'b0, -1);
    n = add_instr("ORI", 6'b001101, 6'h00, 0, 0, 1'b0, -1);
    n = add_instr("BNE", 6'b000101, 6'h00, 0, 0, 1'b1, -1);
    n = add_instr("J", 6'b000010, 6'h00, 0, 0, 1'b0, -1);         chk_int("len_j", n, 3);
    n = add_instr("JR", 6'b000000, 6'b001000, 0, 0, 1'b0, -1);
    n = add_instr("JAL", 6'b000011, 6'h00, 0, 0, 1'b0, -1);
    n = add_instr("SUB", 6'b000000, 6'b100010, 2, 0, 1'b0, -1);
    n = add_instr("DIV", 6'b000000, 6'b011010, 0, 0, 1'b0, -1);
    n = add_instr("LW14", 6'b100011, 6'h00, 14, 14, 1'b0, -1);    chk_int("len_lw_wait14", n, 33);
    n = add_instr("SW_RST", 6'b101011, 6'h00, 0, 5, 1'b0, 4);
    n = add_instr("ADD", 6'b000000, 6'b100000, 1, 0, 1'b0, -1);
    add_timeout();
    n = add_instr("ADD", 6'b000000, 6'b100000, 0, 0, 1'b0, -1);
    n = add_instr("ILLEGAL", 6'b111111, 6'h00, 0, 0, 1'b0, -1);
    n = add_instr("OR", 6'b000000, 6'b100101, 0, 0, 1'b0, -1);

    for (int i = 0; i < q.size(); i++) begin
      @(posedge clk);
      #1;
      rst           = q[i].rst;
      bus.mem_ready = q[i].rdy;
      alu_zero      = q[i].zero;
      opcode        = q[i].op;
      func          = q[i].fn;
      @(negedge clk);
      total++;
      if (dut_vec !== q[i].exp) begin
        bad++;
        $display("FAIL step%0d %0s outputs got=%h expected=%h", i, q[i].nm, dut_vec, q[i].exp);
      end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
